sm4_tau_serial: RTL and testbench



---
 rtl/sm4_pkg.sv | 42 ++++
 rtl/sm4_sbox_rom.sv | 13 +
 rtl/sm4_tau_serial.sv | 126 ++++++++++++
 tb/tb_sm4_tau_serial.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: S-box table, tau engine FSM states, width helper.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package sm4_pkg;

    // Standard SM4 S-box, entry i is S(i).
    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } sm4_state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sm4_sbox_rom.sv
// SM4 S-box lookup, one byte in, one byte out.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module sm4_sbox_rom
    import sm4_pkg::*;
(
    input  logic [7:0] in_dat,
    output logic [7:0] out_dat
);

    assign out_dat = SM4_SBOX[in_dat];

endmodule

// File: rtl/sm4_tau_serial.sv
// SM4 tau: substitutes every byte of a word, SBOX_LANES bytes per cycle.
// Latency: result valid BEATS cycles after acceptance; one word per BEATS+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready combinational from state and out_ready.
module sm4_tau_serial
    import sm4_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int SBOX_LANES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic                    busy
);

    localparam int DW    = 8 * WORD_BYTES;
    localparam int LW    = 8 * SBOX_LANES;
    localparam int BEATS = WORD_BYTES / SBOX_LANES;
    localparam int BW    = clog2_min1(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    sm4_state_e    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [DW-1:0] work_q, work_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    logic [LW-1:0] lane_in_dat;
    logic [LW-1:0] lane_out_dat;
    logic [DW-1:0] work_sub;

    // Byte-select mux: the current beat's slice of the work word feeds the lanes.
    always_comb begin
        lane_in_dat = '0;
        for (int l = 0; l < SBOX_LANES; l++) begin
            lane_in_dat[l*8 +: 8] = work_q[(int'(beat_q) * SBOX_LANES + l) * 8 +: 8];
        end
    end

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        sm4_sbox_rom u_sbox (
            .in_dat  (lane_in_dat[g*8 +: 8]),
            .out_dat (lane_out_dat[g*8 +: 8])
        );
    end

    // Write-back demux: substituted bytes return to the same slice of the work word.
    always_comb begin
        work_sub = work_q;
        for (int l = 0; l < SBOX_LANES; l++) begin
            work_sub[(int'(beat_q) * SBOX_LANES + l) * 8 +: 8] = lane_out_dat[l*8 +: 8];
        end
    end

    // Next-state logic: accept in IDLE or on the DONE hand-off edge, sweep beats in SUB.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        work_d      = work_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    beat_d  = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                work_d = work_sub;
                if (beat_q == LAST_BEAT) begin
                    out_data_d  = work_sub;
                    out_valid_d = 1'b1;
                    beat_d      = '0;
                    state_d     = ST_DONE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        work_d  = in_data;
                        beat_d  = '0;
                        state_d = ST_SUB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any partial word and clears the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            work_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            work_q      <= work_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign busy      = (state_q == ST_SUB);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_sm4_tau_serial.sv
module tb_sm4_tau_serial;

    localparam logic [7:0] TB_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  busy;
    logic [31:0] in_data  [3];
    logic [31:0] out_data [3];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Instance 0: 1 lane (4 beats), instance 1: 2 lanes (2 beats), instance 2: 4 lanes (1 beat).
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LN = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        sm4_tau_serial #(.WORD_BYTES(4), .SBOX_LANES(LN)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tau_model(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = TB_SBOX[w[k*8 +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] stream_word(input int n);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'((n + 64 * k) & 255);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int bts, n, m, cyc, first_c, last_c;
        bit acc;
        rst       = 3'b111;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        for (int d = 0; d < 3; d++) in_data[d] = 32'h0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready",  32'(in_ready[d]),  32'd1);
            chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
            chk("rst_out_data",  out_data[d],       32'h0);
            chk("rst_busy",      32'(busy[d]),      32'd0);
        end
        rst = 3'b000;
        tick();

        // Defaults: 0x000110ff -> 0xd6902b48, busy for 4 cycles, valid after E0+4.
        out_ready[0] = 1'b1;
        in_data[0]   = 32'h000110ff;
        in_valid[0]  = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_busy", 32'(busy[0]), 32'd1);
            chk("t1_no_valid", 32'(out_valid[0]), 32'd0);
            tick();
        end
        chk("t1_valid", 32'(out_valid[0]), 32'd1);
        chk("t1_data", out_data[0], 32'hd6902b48);
        chk("t1_busy_low", 32'(busy[0]), 32'd0);
        tick();
        chk("t1_idle_valid", 32'(out_valid[0]), 32'd0);
        chk("t1_idle_ready", 32'(in_ready[0]), 32'd1);

        // Four lanes: 0xab000001 -> 0xabd6d690 after E0+1.
        out_ready[2] = 1'b1;
        in_data[2]   = 32'hab000001;
        in_valid[2]  = 1'b1;
        tick();
        in_valid[2] = 1'b0;
        chk("t2_busy", 32'(busy[2]), 32'd1);
        chk("t2_no_valid", 32'(out_valid[2]), 32'd0);
        tick();
        chk("t2_valid", 32'(out_valid[2]), 32'd1);
        chk("t2_data", out_data[2], 32'habd6d690);
        tick();

        // Back-pressure: result 0x2b48d690 held 10 cycles, then hand-off with a new word.
        out_ready[0] = 1'b0;
        in_data[0]   = 32'h10ff0001;
        in_valid[0]  = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid_held", 32'(out_valid[0]), 32'd1);
            chk("bp_data_held", out_data[0], 32'h2b48d690);
            chk("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
            tick();
        end
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 32'hab10ab10;
        #1;
        chk("bp_in_ready_comb", 32'(in_ready[0]), 32'd1);
        tick();
        in_valid[0] = 1'b0;
        chk("bp_accept_busy", 32'(busy[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("bp_no_valid", 32'(out_valid[0]), 32'd0);
            tick();
        end
        chk("bp_new_valid", 32'(out_valid[0]), 32'd1);
        chk("bp_new_data", out_data[0], 32'hab2bab2b);
        tick();

        // Reset during beat 2, then 0xffffffff -> 0x48484848.
        in_data[0]  = 32'h12345678;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        chk("mr_busy_before", 32'(busy[0]), 32'd1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("mr_in_ready", 32'(in_ready[0]), 32'd1);
        chk("mr_out_valid", 32'(out_valid[0]), 32'd0);
        chk("mr_out_data", out_data[0], 32'h0);
        chk("mr_busy", 32'(busy[0]), 32'd0);
        in_data[0]  = 32'hffffffff;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (4) tick();
        chk("mr_after_valid", 32'(out_valid[0]), 32'd1);
        chk("mr_after_data", out_data[0], 32'h48484848);
        tick();

        // in_valid held with in_data changing during SUB/DONE: only the accepted word counts.
        out_ready[0] = 1'b0;
        in_data[0]   = 32'h000110ff;
        in_valid[0]  = 1'b1;
        tick();
        in_data[0] = 32'hffffffff;
        tick();
        in_data[0] = 32'h12345678;
        tick();
        in_data[0] = 32'habababab;
        tick();
        in_data[0] = 32'h01010101;
        tick();
        chk("hold_valid", 32'(out_valid[0]), 32'd1);
        chk("hold_data", out_data[0], 32'hd6902b48);
        in_data[0] = 32'h10101010;
        tick();
        chk("hold_still_done", 32'(out_valid[0]), 32'd1);
        chk("hold_data2", out_data[0], 32'hd6902b48);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        chk("hold_idle", 32'(in_ready[0]), 32'd1);

        // Streaming 256 words through each lane configuration against the table model.
        for (int d = 0; d < 3; d++) begin
            bts = (d == 0) ? 4 : ((d == 1) ? 2 : 1);
            n = 0; m = 0; cyc = 0; first_c = 0; last_c = 0;
            out_ready[d] = 1'b1;
            in_data[d]   = stream_word(0);
            in_valid[d]  = 1'b1;
            acc = in_ready[d];
            while (m < 256 && cyc < 3000) begin
                tick();
                cyc++;
                if (acc) begin
                    n++;
                    if (n < 256) in_data[d] = stream_word(n);
                    else in_valid[d] = 1'b0;
                end
                if (out_valid[d]) begin
                    chk("stream_data", out_data[d], tau_model(stream_word(m)));
                    if (m == 0) first_c = cyc;
                    last_c = cyc;
                    m++;
                end
                acc = in_ready[d] && in_valid[d];
            end
            chk("stream_count", 32'(m), 32'd256);
            chk("stream_rate", 32'(last_c - first_c), 32'(255 * (bts + 1)));
            in_valid[d] = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
